mux_32to1_tdm: RTL



---
 rtl/mux_32to1_tdm.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mux_32to1_tdm.sv
// mux_32to1_tdm: time-division 32-to-1 serializer.
// A parallel lane word is captured through a load handshake and then presented
// one lane per beat on data_o/sel_o under a valid/ready handshake. done_o
// pulses for one cycle after the final beat of each completed word.
// Optional build macro MUX32_SKIP_ZERO_EN: only lanes whose captured bit is 1
// are presented; an all-zero word completes immediately without streaming.
//
// state | meaning
// IDLE  | waiting for a word, load_ready_o follows en_i
// SHIFT | presenting shadow[idx] on data_o, idx on sel_o

module mux_32to1_tdm #(
    parameter int N_LANES = 32,
    parameter int SEL_W   = $clog2(N_LANES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [N_LANES-1:0] in_i,
    input  logic               load_valid_i,
    output logic               load_ready_o,
    output logic               data_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               done_o
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state;
    logic [SEL_W-1:0]   idx;
    logic [N_LANES-1:0] shadow;
    logic               done;

    logic               load_take;
    logic               beat_take;
    logic               last_beat;
    logic [SEL_W-1:0]   next_idx;

`ifdef MUX32_SKIP_ZERO_EN
    // Returns {found, index} of the lowest set bit of w.
    function automatic logic [SEL_W:0] lowest_set(input logic [N_LANES-1:0] w);
        logic [SEL_W:0] r;
        r = '0;
        for (int k = N_LANES - 1; k >= 0; k--) begin
            if (w[k]) r = {1'b1, SEL_W'(k)};
        end
        return r;
    endfunction

    logic [N_LANES-1:0] above;
    logic [SEL_W:0]     next_hit;
    logic [SEL_W:0]     load_hit;

    // Remaining set lanes strictly above the current index, and the next one to present.
    always_comb begin
        above = '0;
        for (int k = 0; k < N_LANES; k++) begin
            above[k] = shadow[k] && (SEL_W'(k) > idx);
        end
        next_hit  = lowest_set(above);
        load_hit  = lowest_set(in_i);
        last_beat = !next_hit[SEL_W];
        next_idx  = next_hit[SEL_W-1:0];
    end
`else
    // Every lane is presented; lane N_LANES-1 closes the word instead of wrapping.
    always_comb begin
        last_beat = (idx == SEL_W'(N_LANES - 1));
        next_idx  = idx + SEL_W'(1);
    end
`endif

    // Handshake outputs; the reset cycle offers and accepts nothing.
    always_comb begin
        load_ready_o = !rst_i && (state == IDLE) && en_i;
        valid_o      = !rst_i && (state == SHIFT) && en_i;
        data_o       = (state == SHIFT) ? shadow[idx] : 1'b0;
        sel_o        = (state == SHIFT) ? idx : '0;
        done_o       = done;
        load_take    = load_valid_i && load_ready_o;
        beat_take    = valid_o && ready_i;
    end

    // Load capture, beat sequencing and the completion pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            idx    <= '0;
            shadow <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_take) begin
                        shadow <= in_i;
`ifdef MUX32_SKIP_ZERO_EN
                        if (load_hit[SEL_W]) begin
                            idx   <= load_hit[SEL_W-1:0];
                            state <= SHIFT;
                        end else begin
                            idx  <= '0;
                            done <= 1'b1;
                        end
`else
                        idx   <= '0;
                        state <= SHIFT;
`endif
                    end
                end
                SHIFT: begin
                    if (beat_take) begin
                        if (last_beat) begin
                            state <= IDLE;
                            idx   <= '0;
                            done  <= 1'b1;
                        end else begin
                            idx <= next_idx;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule
